// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm watchdog bank.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRIPPED  = 2'd2
    } ch_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } rs_state_e;

    // Counter width able to hold 0..timeout.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alarm_wd_channel.sv
// One watchdog channel: kick-cleared tick counter plus DISARMED/ARMED/TRIPPED FSM.
module alarm_wd_channel
    import alarm_pkg::*;
#(
    parameter int TIMEOUT = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,       // already masked by standby
    input  logic kick_i,
    input  logic en_i,
    input  logic force_i,
    input  logic err_rst_i,
    output logic alarm_o,
    output logic trip_o        // high in the cycle the channel enters TRIPPED
);

    localparam int              CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    ch_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           trip;

    // State and counter registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DISARMED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: kick beats a counting tick, forced test trips regardless.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trip    = 1'b0;
        case (state_q)
            DISARMED: begin
                cnt_d = '0;
                if (en_i) state_d = ARMED;
            end
            ARMED: begin
                if (!en_i) begin
                    state_d = DISARMED;
                    cnt_d   = '0;
                end else if (tick_i && force_i) begin
                    trip = 1'b1;
                end else if (kick_i) begin
                    cnt_d = '0;
                end else if (tick_i) begin
                    if (cnt_q == LAST) trip = 1'b1;
                    else               cnt_d = cnt_q + 1'b1;
                end
                if (trip) begin
                    state_d = TRIPPED;
                    cnt_d   = '0;
                end
            end
            TRIPPED: begin
                if (err_rst_i) begin
                    cnt_d   = '0;
                    state_d = en_i ? ARMED : DISARMED;
                end
            end
            default: begin
                state_d = DISARMED;
                cnt_d   = '0;
            end
        endcase
    end

    assign alarm_o = (state_q == TRIPPED);
    assign trip_o  = trip;

endmodule

// File: rtl/alarm_watchdog_bank.sv
// Bank of watchdog channels with shared restart pulse, first-cause capture and warning filter.
module alarm_watchdog_bank
    import alarm_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TIMEOUT     = 5,
    parameter int RESTART_LEN = 3,
    parameter int FILT_MAX    = 15,
    parameter int WARN_ON     = 12,
    parameter int WARN_OFF    = 4,
    parameter int UP_STEP     = 4
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] kick,
    input  logic [N_CH-1:0] alarm_en,
    input  logic            test_force,
    input  logic            err_rst,
    input  logic            standby,
    output logic [N_CH-1:0] alarm_lat,
    output logic            any_alarm,
    output logic [3:0]      first_cause,
    output logic            restart_pulse,
    output logic            restart_light,
    output logic            warn
);

    localparam int LW = $clog2(FILT_MAX + 1);
    localparam int PW = $clog2(RESTART_LEN + 1);

    logic            tick_run;
    logic [N_CH-1:0] trip;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] alarm_prev_q;

    rs_state_e       rs_q, rs_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            light_q, light_d;
    logic [3:0]      cause_q, cause_d;
    logic [LW-1:0]   level_q, level_d;
    logic            warn_q, warn_d;

    // Standby freezes everything that is paced by the timebase.
    assign tick_run = tick & ~standby;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        alarm_wd_channel #(.TIMEOUT(TIMEOUT)) u_ch (
            .clk_i    (CLOCK),
            .rst_i    (rst),
            .tick_i   (tick_run),
            .kick_i   (kick[g]),
            .en_i     (alarm_en[g]),
            .force_i  (test_force),
            .err_rst_i(err_rst),
            .alarm_o  (alarm_lat[g]),
            .trip_o   (trip[g])
        );
    end

    assign any_alarm = |alarm_lat;
    assign rise      = alarm_lat & ~alarm_prev_q;

    // Registers for restart FSM, first cause, filter and edge detection.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            alarm_prev_q <= '0;
            rs_q         <= IDLE;
            pcnt_q       <= '0;
            light_q      <= 1'b0;
            cause_q      <= '0;
            level_q      <= '0;
            warn_q       <= 1'b0;
        end else begin
            alarm_prev_q <= alarm_lat;
            rs_q         <= rs_d;
            pcnt_q       <= pcnt_d;
            light_q      <= light_d;
            cause_q      <= cause_d;
            level_q      <= level_d;
            warn_q       <= warn_d;
        end
    end

    // Restart pulse: a fresh latch edge starts one fixed-length pulse; no retrigger.
    always_comb begin
        rs_d   = rs_q;
        pcnt_d = pcnt_q;
        case (rs_q)
            IDLE: begin
                if ((|rise) && !standby) begin
                    rs_d   = PULSE;
                    pcnt_d = '0;
                end
            end
            PULSE: begin
                if (pcnt_q == PW'(RESTART_LEN - 1)) begin
                    rs_d   = IDLE;
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: begin
                rs_d   = IDLE;
                pcnt_d = '0;
            end
        endcase
    end

    // Restart light and first cause; a trip coinciding with err_rst keeps the light lit.
    always_comb begin
        light_d = light_q;
        cause_d = cause_q;
        if (|rise)                       light_d = 1'b1;
        else if (err_rst && !(|trip))    light_d = 1'b0;

        if ((|rise) && !(|alarm_prev_q)) cause_d = lowest_index(16'(rise));
        else if (!any_alarm)             cause_d = '0;
    end

    // Hysteretic warning filter, stepped on each live tick.
    always_comb begin
        level_d = level_q;
        warn_d  = warn_q;
        if (tick_run) begin
            if (any_alarm) begin
                if (int'(level_q) + UP_STEP >= FILT_MAX) level_d = LW'(FILT_MAX);
                else                                      level_d = level_q + LW'(UP_STEP);
            end else if (level_q != '0) begin
                level_d = level_q - 1'b1;
            end
        end
        if (int'(level_d) >= WARN_ON)       warn_d = 1'b1;
        else if (int'(level_d) <= WARN_OFF) warn_d = 1'b0;
    end

    assign restart_pulse = (rs_q == PULSE);
    assign restart_light = light_q;
    assign first_cause   = cause_q;
    assign warn          = warn_q;

endmodule
